rv32_ahb_sram_slave: RTL and testbench

AHB-Lite slave that fronts a synchronous single-port SRAM macro, serving instruction fetches and loads/stores issued by the RV32IM core's AHB-Lite master through the SoC interconnect. It converts AHB address/data phases into SRAM chip-select, write-enable and byte-enable strobes. It inserts a wait state only on write-then-read port conflicts and returns a two-cycle ERROR response for illegal transfers.

---
 rtl/pkg_rv32_types.sv | 9 +
 rtl/rv32_ahb_sram_slave_if.sv | 16 +
 rtl/rv32_ahb_lane_decode.sv | 14 +
 rtl/rv32_ahb_sram_slave.sv | 61 ++++++
 tb/tb_rv32_ahb_sram_slave.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pkg_rv32_types.sv
// pkg_rv32_types: shared RV32 SoC types, including AHB-Lite encodings and SRAM slave FSM states
package pkg_rv32_types;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_e;
  typedef enum logic [2:0] {HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD} hsize_e;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_RD_DATA, S_WR_DATA, S_RAW_WAIT, S_ERR1, S_ERR2} ahb_sram_state_e;
endpackage

// File: rtl/rv32_ahb_sram_slave_if.sv
// rv32_ahb_sram_slave_if: AHB-Lite bus signals seen by the SRAM slave
interface rv32_ahb_sram_slave_if;
  import pkg_rv32_types::*;
  logic HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE;
  logic [XLEN-1:0] HADDR, HWDATA, HRDATA;
  modport slave (
    input HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input HREADY, HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/rv32_ahb_lane_decode.sv
// rv32_ahb_lane_decode: little-endian byte enables and misalignment flag from HSIZE and HADDR[1:0]
module rv32_ahb_lane_decode import pkg_rv32_types::*; (
  input  logic [2:0] size,
  input  logic [1:0] addr,
  output logic [3:0] be,
  output logic       misalign
);
  always_comb begin
    be = size == HSIZE_BYTE ? 4'b0001 << addr :
         size == HSIZE_HALF ? (addr[1] ? 4'b1100 : 4'b0011) :
         size == HSIZE_WORD ? 4'b1111 : 4'b0000;
    misalign = size == HSIZE_HALF ? addr[0] : (size == HSIZE_WORD && addr != 2'd0);
  end
endmodule

// File: rtl/rv32_ahb_sram_slave.sv
// rv32_ahb_sram_slave: AHB-Lite slave in front of a single-port synchronous SRAM macro
module rv32_ahb_sram_slave import pkg_rv32_types::*; #(
  parameter int MEM_WORDS = 16384,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  rv32_ahb_sram_slave_if.slave ahb,
  output logic                sram_cs,
  output logic                sram_we,
  output logic [3:0]          sram_be,
  output logic [AW-1:0]       sram_addr,
  output logic [XLEN-1:0]     sram_wdata,
  input  logic [XLEN-1:0]     sram_rdata
);
  ahb_sram_state_e state, state_nx;
  logic [AW-1:0] addr_q, idx;
  logic [3:0] be_q, lane_be;
  logic misalign, go, legal, acc, conflict, rd_now, held, unused_haddr;
  assign idx = ahb.HADDR[AW+1:2];
  assign unused_haddr = ^ahb.HADDR[XLEN-1:AW+2];
  rv32_ahb_lane_decode u_lane (
    .size(ahb.HSIZE), .addr(ahb.HADDR[1:0]), .be(lane_be), .misalign(misalign)
  );
  assign go = rst_n && ahb.HSEL && ahb.HTRANS[1];
  assign legal = ahb.HSIZE <= HSIZE_WORD && !misalign && {1'b0, idx} < (AW+1)'(MEM_WORDS);
  assign acc = go && ahb.HREADY && (state inside {S_IDLE, S_RD_DATA, S_WR_DATA, S_ERR2});
  // conflict ignores HREADY: during a write data phase HREADY is our own HREADYOUT
  assign conflict = state == S_WR_DATA && go && legal && !ahb.HWRITE;
  assign rd_now = acc && legal && !ahb.HWRITE && state != S_WR_DATA;
  assign held = state == S_WR_DATA || state == S_RAW_WAIT;
  assign ahb.HREADYOUT = !(state == S_ERR1 || conflict);
  assign ahb.HRESP = (state == S_ERR1 || state == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign ahb.HRDATA = state == S_RD_DATA ? sram_rdata : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      addr_q <= '0;
      be_q <= '0;
    end else begin
      state <= state_nx;
      if ((acc || conflict) && legal) begin
        addr_q <= idx;
        be_q <= lane_be;
      end
    end
  end
  always_comb begin
    state_nx = state == S_RAW_WAIT ? S_RD_DATA :
               state == S_ERR1     ? S_ERR2 :
               conflict            ? S_RAW_WAIT :
               !acc                ? S_IDLE :
               !legal              ? S_ERR1 :
               ahb.HWRITE          ? S_WR_DATA : S_RD_DATA;
    sram_cs = held || rd_now;
    sram_we = state == S_WR_DATA;
    sram_be = held ? be_q : rd_now ? lane_be : '0;
    sram_addr = held ? addr_q : rd_now ? idx : '0;
    sram_wdata = sram_we ? ahb.HWDATA : '0;
  end
endmodule

// File: tb/tb_rv32_ahb_sram_slave.sv
// tb_rv32_ahb_sram_slave: randomized AHB master, SRAM model and transaction-level reference for the SRAM slave
module tb_rv32_ahb_sram_slave;
  import pkg_rv32_types::*;
  localparam int MW = 1000;
  localparam int AW = 10;
  typedef struct {
    bit          wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  tr;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sram_cs, sram_we;
  logic [3:0] sram_be;
  logic [AW-1:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  bit [31:0] mem [1024];
  bit [31:0] ref_mem [1024];
  xfer_t xq [65];
  logic [31:0] got_data [65], exp_data [65];
  int got_wait [65], exp_wait [65];
  logic got_resp0 [65], got_resp1 [65], exp_resp [65];
  int checks = 0, passed = 0, cs_cnt = 0, stall_cnt = 0;
  logic [3:0] we_be;

  rv32_ahb_sram_slave_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  rv32_ahb_sram_slave #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .ahb(bus),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_be(sram_be),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_cs) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else sram_rdata <= mem[sram_addr];
    end
  end

  function automatic bit legal_x(input xfer_t x);
    return x.sz <= 3'd2 && (x.a % (32'd1 << x.sz)) == 32'd0 && int'(x.a[11:2]) < MW;
  endfunction

  // Transaction-level expectations: data from a word array, one stall for a write
  // directly followed by a legal read, two-cycle ERROR for an illegal transfer.
  function automatic void predict(input int n);
    for (int i = 0; i < n; i++) begin
      bit act = xq[i].tr[1];
      bit ok = legal_x(xq[i]);
      int w = int'(xq[i].a[11:2]);
      int off = int'(xq[i].a[1:0]);
      int nb = 1 << int'(xq[i].sz);
      bit nxt_rd = (i + 1 < n) && xq[i+1].tr[1] && legal_x(xq[i+1]) && !xq[i+1].wr;
      exp_resp[i] = act && !ok;
      exp_wait[i] = ((act && !ok) || (act && ok && xq[i].wr && nxt_rd)) ? 1 : 0;
      exp_data[i] = '0;
      if (act && ok && xq[i].wr) begin
        for (int b = off; b < off + nb; b++) ref_mem[w][8*b +: 8] = xq[i].d[8*b +: 8];
      end else if (act && ok) exp_data[i] = ref_mem[w];
    end
  endfunction

  function automatic void set_x(input int i, input bit wr, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] d, input logic [1:0] tr);
    xq[i].wr = wr; xq[i].sz = sz; xq[i].a = a; xq[i].d = d; xq[i].tr = tr;
  endfunction

  task automatic bus_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'd0; bus.HWRITE = 1'b0;
    bus.HSIZE = 3'd0; bus.HADDR = '0; bus.HWDATA = '0;
  endtask

  // Pipelined AHB master; entered and left at posedge+1
  task automatic run(input int n);
    int ai = 0, di = -1, w = 0, cyc = 0;
    logic ro;
    cs_cnt = 0; stall_cnt = 0; we_be = '0;
    for (int i = 0; i < n; i++) got_wait[i] = -1;
    while ((ai < n || di >= 0) && cyc < 500) begin
      if (ai < n) begin
        bus.HSEL = 1'b1; bus.HTRANS = xq[ai].tr; bus.HWRITE = xq[ai].wr;
        bus.HSIZE = xq[ai].sz; bus.HADDR = xq[ai].a;
      end else begin
        bus.HSEL = 1'b0; bus.HTRANS = 2'd0;
      end
      bus.HWDATA = di >= 0 ? xq[di].d : '0;
      @(negedge clk);
      ro = bus.HREADYOUT;
      if (!ro) stall_cnt++;
      if (sram_cs) cs_cnt++;
      if (sram_we) we_be = sram_be;
      if (di >= 0) begin
        if (w == 0) got_resp0[di] = bus.HRESP;
        got_resp1[di] = bus.HRESP;
        got_data[di] = bus.HRDATA;
        if (!ro) w++;
      end
      @(posedge clk); #1;
      cyc++;
      if (ro) begin
        if (di >= 0) got_wait[di] = w;
        w = 0;
        di = ai < n ? ai : -1;
        if (ai < n) ai++;
      end
    end
    checks++;
    if (cyc >= 500) $display("FAIL run_timeout cycles=%0d limit=500", cyc); else passed++;
    bus_idle();
  endtask

  task automatic test_reset();
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.HREADYOUT !== 1'b1) $display("FAIL rst_hready_in got %b exp 1", bus.HREADYOUT); else passed++;
    checks++; if (sram_cs !== 1'b0) $display("FAIL rst_cs_in got %b exp 0", sram_cs); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.HREADYOUT !== 1'b1) $display("FAIL rst_hready got %b exp 1", bus.HREADYOUT); else passed++;
    checks++; if (bus.HRESP !== 1'b0) $display("FAIL rst_hresp got %b exp 0", bus.HRESP); else passed++;
    checks++; if (bus.HRDATA !== 32'h0) $display("FAIL rst_hrdata got %h exp 0", bus.HRDATA); else passed++;
    checks++; if ({sram_cs, sram_we, sram_be} !== 6'b0) $display("FAIL rst_strobes got %b exp 0", {sram_cs, sram_we, sram_be}); else passed++;
    checks++; if (sram_addr !== '0) $display("FAIL rst_addr got %h exp 0", sram_addr); else passed++;
    checks++; if (sram_wdata !== 32'h0) $display("FAIL rst_wdata got %h exp 0", sram_wdata); else passed++;
  endtask

  task automatic test_write_read();
    set_x(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 2'd2);
    set_x(1, 0, 3'd2, 32'h10, 32'h0, 2'd2);
    predict(2); run(2);
    checks++; if (we_be !== 4'b1111) $display("FAIL wr_rd_be got %b exp 1111", we_be); else passed++;
    checks++; if (stall_cnt !== 1) $display("FAIL wr_rd_stalls got %0d exp 1", stall_cnt); else passed++;
    checks++; if (got_data[1] !== 32'hDEADBEEF) $display("FAIL wr_rd_data got %h exp deadbeef", got_data[1]); else passed++;
    for (int i = 0; i < 2; i++) begin
      checks++; if (got_wait[i] !== exp_wait[i]) $display("FAIL wr_rd_wait[%0d] got %0d exp %0d", i, got_wait[i], exp_wait[i]); else passed++;
      checks++; if ({got_resp0[i], got_resp1[i]} !== {2{exp_resp[i]}}) $display("FAIL wr_rd_resp[%0d] got %b exp %b", i, {got_resp0[i], got_resp1[i]}, {2{exp_resp[i]}}); else passed++;
    end
  endtask

  task automatic test_byte_write();
    set_x(0, 1, 3'd2, 32'h10, 32'h11223344, 2'd2);
    set_x(1, 1, 3'd0, 32'h13, 32'hAA000000, 2'd2);
    set_x(2, 0, 3'd0, 32'h0, 32'h0, 2'd0);
    set_x(3, 0, 3'd2, 32'h10, 32'h0, 2'd2);
    predict(4); run(4);
    checks++; if (we_be !== 4'b1000) $display("FAIL byte_be got %b exp 1000", we_be); else passed++;
    checks++; if (stall_cnt !== 0) $display("FAIL byte_stalls got %0d exp 0", stall_cnt); else passed++;
    checks++; if (got_data[3] !== 32'hAA223344) $display("FAIL byte_data got %h exp aa223344", got_data[3]); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_wait[i] !== exp_wait[i]) $display("FAIL byte_wait[%0d] got %0d exp %0d", i, got_wait[i], exp_wait[i]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) set_x(i, 0, 3'd2, 32'(4 * i), 32'h0, i == 0 ? 2'd2 : 2'd3);
    predict(4); run(4);
    checks++; if (stall_cnt !== 0) $display("FAIL b2b_stalls got %0d exp 0", stall_cnt); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++; if (got_data[i] !== exp_data[i]) $display("FAIL b2b_data[%0d] got %h exp %h", i, got_data[i], exp_data[i]); else passed++;
      checks++; if (got_resp1[i] !== 1'b0) $display("FAIL b2b_resp[%0d] got %b exp 0", i, got_resp1[i]); else passed++;
    end
  endtask

  task automatic test_error();
    set_x(0, 0, 3'd1, 32'h01, 32'h0, 2'd2);
    predict(1); run(1);
    checks++; if (got_wait[0] !== 1) $display("FAIL err_half_wait got %0d exp 1", got_wait[0]); else passed++;
    checks++; if ({got_resp0[0], got_resp1[0]} !== 2'b11) $display("FAIL err_half_resp got %b exp 11", {got_resp0[0], got_resp1[0]}); else passed++;
    checks++; if (cs_cnt !== 0) $display("FAIL err_half_cs got %0d exp 0", cs_cnt); else passed++;
    set_x(0, 0, 3'd2, 32'hFA0, 32'h0, 2'd2);
    set_x(1, 0, 3'd2, 32'h0, 32'h0, 2'd2);
    predict(2); run(2);
    checks++; if ({got_wait[0], got_resp0[0], got_resp1[0]} !== {32'd1, 2'b11}) $display("FAIL err_range got wait=%0d resp=%b%b exp wait=1 resp=11", got_wait[0], got_resp0[0], got_resp1[0]); else passed++;
    checks++; if (cs_cnt !== 1) $display("FAIL err_range_cs got %0d exp 1", cs_cnt); else passed++;
    checks++; if ({got_wait[1], got_resp1[1]} !== {32'd0, 1'b0}) $display("FAIL err_next_ok got wait=%0d resp=%b exp wait=0 resp=0", got_wait[1], got_resp1[1]); else passed++;
    checks++; if (got_data[1] !== exp_data[1]) $display("FAIL err_next_data got %h exp %h", got_data[1], exp_data[1]); else passed++;
  endtask

  task automatic test_reset_mid_write();
    set_x(0, 1, 3'd2, 32'h20, 32'hCAFEF00D, 2'd2);
    predict(1); run(1);
    bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HWRITE = 1'b1; bus.HSIZE = 3'd2; bus.HADDR = 32'h20;
    @(posedge clk); #1;
    bus.HSEL = 1'b0; bus.HTRANS = 2'd0; bus.HWDATA = 32'h12345678;
    #1;
    checks++; if (sram_we !== 1'b1) $display("FAIL mid_pre_we got %b exp 1", sram_we); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if ({sram_cs, sram_we} !== 2'b00) $display("FAIL mid_strobes got %b exp 00", {sram_cs, sram_we}); else passed++;
    @(posedge clk); #1;
    checks++; if (mem[8] !== ref_mem[8]) $display("FAIL mid_mem got %h exp %h", mem[8], ref_mem[8]); else passed++;
    @(negedge clk); rst_n = 1'b1; bus_idle();
    #1;
    checks++; if ({bus.HREADYOUT, bus.HRESP} !== 2'b10) $display("FAIL mid_release got %b exp 10", {bus.HREADYOUT, bus.HRESP}); else passed++;
    @(posedge clk); #1;
    set_x(0, 0, 3'd2, 32'h20, 32'h0, 2'd2);
    predict(1); run(1);
    checks++; if (got_data[0] !== 32'hCAFEF00D) $display("FAIL mid_readback got %h exp cafef00d", got_data[0]); else passed++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) begin
        int k = int'($urandom_range(0, 9));
        xq[i].tr = k == 0 ? 2'd0 : k == 1 ? 2'd1 : k < 6 ? 2'd2 : 2'd3;
        xq[i].wr = $urandom_range(0, 1) == 1;
        xq[i].sz = $urandom_range(0, 11) == 0 ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
        xq[i].a = $urandom_range(0, 9) == 0 ? 32'hFA0 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 63));
        if ($urandom_range(0, 4) != 0 && xq[i].sz <= 3'd2) xq[i].a = xq[i].a & ~((32'd1 << xq[i].sz) - 32'd1);
        xq[i].d = $urandom;
      end
      predict(40); run(40);
      for (int i = 0; i < 40; i++) begin
        checks++; if (got_data[i] !== exp_data[i]) $display("FAIL rnd%0d_data[%0d] got %h exp %h", r, i, got_data[i], exp_data[i]); else passed++;
        checks++; if (got_wait[i] !== exp_wait[i]) $display("FAIL rnd%0d_wait[%0d] got %0d exp %0d", r, i, got_wait[i], exp_wait[i]); else passed++;
        checks++; if ({got_resp0[i], got_resp1[i]} !== {2{exp_resp[i]}}) $display("FAIL rnd%0d_resp[%0d] got %b exp %b", r, i, {got_resp0[i], got_resp1[i]}, {2{exp_resp[i]}}); else passed++;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_back_to_back();
    test_error();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
